// File: rtl/bsg_dff_reset_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_dff_reset_pipe_pkg
//  Description : Shared helper for the bsg_dff_reset_pipe retiming pipe.
//                Holds the per-stage advance equation so the top level and
//                any future variants compute stage advance the same way.
//  Revision    : 1.0  initial release
// ============================================================================
package bsg_dff_reset_pipe_pkg;

    // A stage may load when it is empty (the bubble is overwritten) or when
    // the stage below it is itself moving on this cycle.
    function automatic logic stage_adv(input logic v, input logic adv_down);
        return ~v | adv_down;
    endfunction

endpackage : bsg_dff_reset_pipe_pkg
`default_nettype wire

// File: rtl/bsg_dff_reset_en_stage.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_dff_reset_en_stage
//  Description : One pipe stage: a valid bit plus width_p data bits with
//                synchronous reset to {1'b0, reset_val_p} and a load enable.
//                A separate valid-clear input drops the valid bit while
//                leaving the data untouched.
//  Ports       : clk_i    - clock
//                reset_i  - synchronous active-high reset
//                en_i     - load v_i/data_i this cycle
//                clr_v_i  - clear valid bit only (data held)
//                v_i      - incoming valid
//                data_i   - incoming payload
//                v_o      - stored valid
//                data_o   - stored payload
//  Revision    : 1.0  initial release
// ============================================================================
module bsg_dff_reset_en_stage
    import bsg_dff_reset_pipe_pkg::*;
#(
    parameter int                 width_p     = 6,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               clr_v_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    logic               r_v;
    logic [width_p-1:0] r_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v <= 1'b0;
            r_d <= reset_val_p;
        end else if (clr_v_i) begin
            r_v <= 1'b0;
        end else if (en_i) begin
            // Data follows the valid bit even when the item is a bubble;
            // the payload of an invalid stage is simply don't-care.
            r_v <= v_i;
            r_d <= data_i;
        end
    end

    assign v_o    = r_v;
    assign data_o = r_d;

endmodule : bsg_dff_reset_en_stage
`default_nettype wire

// File: rtl/bsg_dff_reset_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_dff_reset_pipe
//  Description : els_p-stage retiming pipe with per-stage valid bits,
//                valid/ready input, valid/yumi output and bubble collapsing.
//                Capacity is exactly els_p items; zero-stall latency is
//                els_p cycles; sustained throughput is one item per cycle.
//  Ports       : clk_i    - clock
//                reset_i  - synchronous active-high reset
//                clear_i  - (BSG_DFF_RESET_PIPE_CLEAR_EN only) drop all
//                           valid bits, keep data, refuse input this cycle
//                valid_i  - producer offers data_i
//                data_i   - input payload
//                ready_o  - pipe accepts data_i this cycle
//                valid_o  - last stage holds an item
//                data_o   - last stage payload
//                yumi_i   - consumer takes data_o (only when valid_o=1)
//  Macro       : BSG_DFF_RESET_PIPE_CLEAR_EN enables the clear_i port.
//  Revision    : 1.0  initial release
// ============================================================================
module bsg_dff_reset_pipe
    import bsg_dff_reset_pipe_pkg::*;
#(
    parameter int                 width_p     = 6,
    parameter int                 els_p       = 2,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
`ifdef BSG_DFF_RESET_PIPE_CLEAR_EN
    input  logic               clear_i,
`endif
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic               w_clear;
    logic               w_adv [els_p];
    logic               w_v   [els_p];
    logic [width_p-1:0] w_d   [els_p];

`ifdef BSG_DFF_RESET_PIPE_CLEAR_EN
    assign w_clear = clear_i;
`else
    assign w_clear = 1'b0;
`endif

    genvar k;
    generate
        for (k = 0; k < els_p; k++) begin : g_stage
            logic               w_v_in;
            logic [width_p-1:0] w_d_in;

            if (k == 0) begin : g_first
                assign w_v_in = valid_i;
                assign w_d_in = data_i;
            end else begin : g_rest
                assign w_v_in = w_v[k-1];
                assign w_d_in = w_d[k-1];
            end

            // Advance chain resolves from the output side back to the input
            // side, so an empty stage anywhere lets everything above it move.
            if (k == els_p - 1) begin : g_last
                assign w_adv[k] = stage_adv(w_v[k], yumi_i);
            end else begin : g_mid
                assign w_adv[k] = stage_adv(w_v[k], w_adv[k+1]);
            end

            bsg_dff_reset_en_stage #(
                .width_p     (width_p),
                .reset_val_p (reset_val_p)
            ) u_stage (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .en_i    (w_adv[k]),
                .clr_v_i (w_clear),
                .v_i     (w_v_in),
                .data_i  (w_d_in),
                .v_o     (w_v[k]),
                .data_o  (w_d[k])
            );
        end
    endgenerate

    // Clear takes precedence over loading inside each stage, so masking
    // ready here is enough to guarantee no input is accepted during clear.
    assign ready_o = w_adv[0] & ~w_clear;
    assign valid_o = w_v[els_p-1];
    assign data_o  = w_d[els_p-1];

endmodule : bsg_dff_reset_pipe
`default_nettype wire

// File: tb/tb_bsg_dff_reset_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_dff_reset_pipe
//  Description : Directed, scoreboard-based bench for bsg_dff_reset_pipe
//                (width 6, three stages, reset value 6'h2A).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bsg_dff_reset_pipe;

    localparam int         W   = 6;
    localparam int         ELS = 3;
    localparam logic [5:0] RV  = 6'h2A;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } item_t;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         clear_i = 1'b0;
    logic         valid_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic         yumi_i = 1'b0;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    bit    lat_on   = 1'b0;
    item_t q[$];

    always #5 clk = ~clk;

    bsg_dff_reset_pipe #(
        .width_p     (W),
        .els_p       (ELS),
        .reset_val_p (RV)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
`ifdef BSG_DFF_RESET_PIPE_CLEAR_EN
        .clear_i (clear_i),
`endif
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ymode: 0 = yumi low, 1 = yumi high, 2 = yumi follows valid_o
    task automatic step(input bit v, input logic [W-1:0] d, input int ymode,
                        input bit rst = 1'b0, input bit clr = 1'b0);
        logic  exp_ready;
        item_t it;
        valid_i = v;
        data_i  = d;
        yumi_i  = (ymode == 2) ? valid_o : (ymode == 1);
        reset_i = rst;
        clear_i = clr;
        #1;
        if (!rst) begin
            exp_ready = clr ? 1'b0 : ((q.size() < ELS) || yumi_i);
            chk("ready", {31'd0, ready_o}, {31'd0, exp_ready});
            if (q.size() == 0)
                chk("empty_valid", {31'd0, valid_o}, 32'd0);
            if (yumi_i) begin
                chk("yumi_legal", {31'd0, valid_o}, 32'd1);
                if (q.size() == 0) begin
                    chk("pop_nonempty", q.size(), 32'd1);
                end else begin
                    it = q.pop_front();
                    chk("data_out", {26'd0, data_o}, {26'd0, it.d});
                    if (lat_on)
                        chk("latency", cyc - it.c, ELS);
                end
            end
            if (v && exp_ready) begin
                it.d = d;
                it.c = cyc;
                q.push_back(it);
            end
        end
        @(posedge clk);
        if (rst || clr) q.delete();
        cyc++;
        @(negedge clk);
        reset_i = 1'b0;
        clear_i = 1'b0;
        valid_i = 1'b0;
        yumi_i  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++)
            step(1'b0, '0, 2);
        chk("drain_timeout", q.size(), 32'd0);
    endtask

    initial begin
        @(negedge clk);

        // Reset state
        step(1'b0, '0, 0, 1'b1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_data",  {26'd0, data_o},  {26'd0, RV});
        chk("rst_ready", {31'd0, ready_o}, 32'd1);

        // Streaming with yumi tied to valid_o; every item must take ELS cycles
        lat_on = 1'b1;
        for (int i = 1; i <= 8; i++)
            step(1'b1, W'(i), 2);
        drain();
        lat_on = 1'b0;

        // Backpressure: fill, confirm full, then dequeue and enqueue together
        step(1'b1, 6'h11, 0);
        step(1'b1, 6'h12, 0);
        step(1'b1, 6'h13, 0);
        step(1'b1, 6'h14, 0);
        chk("full_head", {26'd0, data_o}, 32'h11);
        step(1'b1, 6'h14, 1);
        drain();

        // Bubble collapse: gaps between items do not cost capacity
        step(1'b1, 6'h21, 0);
        step(1'b0, '0, 0);
        step(1'b0, '0, 0);
        step(1'b1, 6'h22, 0);
        step(1'b1, 6'h23, 0);
        step(1'b1, 6'h24, 0);
        chk("bubble_valid", {31'd0, valid_o}, 32'd1);
        chk("bubble_head",  {26'd0, data_o},  32'h21);
        drain();

        // Reset with items in flight and a simultaneous offer
        step(1'b1, 6'h31, 0);
        step(1'b1, 6'h32, 0);
        step(1'b1, 6'h3F, 0, 1'b1);
        chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("mid_rst_data",  {26'd0, data_o},  {26'd0, RV});
        for (int i = 0; i < 5; i++)
            step(1'b0, '0, 2);

`ifdef BSG_DFF_RESET_PIPE_CLEAR_EN
        // Clear: drops valids, keeps data, refuses input during the clear
        step(1'b1, 6'h41, 0);
        step(1'b1, 6'h42, 0);
        step(1'b1, 6'h43, 0);
        chk("pre_clr_head", {26'd0, data_o}, 32'h41);
        step(1'b1, 6'h44, 0, 1'b0, 1'b1);
        chk("clr_valid", {31'd0, valid_o}, 32'd0);
        chk("clr_data",  {26'd0, data_o},  32'h41);
        chk("clr_ready", {31'd0, ready_o}, 32'd1);
        step(1'b1, 6'h45, 0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_bsg_dff_reset_pipe
`default_nettype wire
